// File: rtl/load_use_interlock.sv
// load_use_interlock
//   Detects load-use hazards between the decode stage and a load that is
//   either still in execute or outstanding in MEM. When one is found, decode
//   is held and a bubble goes into execute. A small FSM tracks the single
//   outstanding load and its destination register. A saturating counter
//   records the number of stall cycles.
//
// Ports
//   clock, reset                  single clock; synchronous active-high reset
//   IDU_valid, IDU_rs1/2(_used)   decode instruction and the sources it reads
//   EXU_valid, EXU_rd, EXU_R_Wen,
//   EXU_mem_ren, EXU_fire         execute instruction, its load and write
//                                 flags, and whether it advances this cycle
//   MEM_rsp_valid                 data for the outstanding load returns
//   flush                         pipeline redirect; kills in-flight work
//   IDU_stall                     hold decode and insert an execute bubble
//   load_pending, pending_rd      outstanding load and its destination
//   stall_cnt                     saturating stall-cycle count
module load_use_interlock #(
    parameter int unsigned CNT_W = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             IDU_valid,
    input  logic [4:0]       IDU_rs1,
    input  logic [4:0]       IDU_rs2,
    input  logic             IDU_rs1_used,
    input  logic             IDU_rs2_used,
    input  logic             EXU_valid,
    input  logic [4:0]       EXU_rd,
    input  logic             EXU_R_Wen,
    input  logic             EXU_mem_ren,
    input  logic             EXU_fire,
    input  logic             MEM_rsp_valid,
    input  logic             flush,
    output logic             IDU_stall,
    output logic             load_pending,
    output logic [4:0]       pending_rd,
    output logic [CNT_W-1:0] stall_cnt
);

    typedef enum logic [0:0] {
        StIdle,
        StLoadWait
    } state_e;

    state_e state;

    logic dep_ex;
    logic dep_mem;
    logic ex_hazard;
    logic mem_hazard;
    logic capture;

    // x0 is hardwired zero, so it never creates a dependency.
    assign dep_ex = (EXU_rd != 5'd0) &&
                    ((IDU_rs1_used && (IDU_rs1 == EXU_rd)) ||
                     (IDU_rs2_used && (IDU_rs2 == EXU_rd)));

    assign dep_mem = (pending_rd != 5'd0) &&
                     ((IDU_rs1_used && (IDU_rs1 == pending_rd)) ||
                      (IDU_rs2_used && (IDU_rs2 == pending_rd)));

    assign ex_hazard = IDU_valid && EXU_valid && EXU_R_Wen && EXU_mem_ren && dep_ex;

    // Data returning this cycle is forwarded, so it does not stall.
    assign mem_hazard = IDU_valid && load_pending && dep_mem && !MEM_rsp_valid;

    // Reset gating keeps the stall low while reset is high.
    assign IDU_stall = (ex_hazard || mem_hazard) && !flush && !reset;

    assign capture = EXU_fire && EXU_valid && EXU_mem_ren && EXU_R_Wen && (EXU_rd != 5'd0);

    // Outstanding-load FSM. Priority: reset, flush, capture, response.
    // A capture while in LOAD_WAIT retires the old load (with or without
    // a response) and tracks the new destination.
    always_ff @(posedge clock) begin
        if (reset) begin
            state        <= StIdle;
            load_pending <= 1'b0;
            pending_rd   <= 5'd0;
        end else if (flush) begin
            state        <= StIdle;
            load_pending <= 1'b0;
            pending_rd   <= 5'd0;
        end else if (capture) begin
            state        <= StLoadWait;
            load_pending <= 1'b1;
            pending_rd   <= EXU_rd;
        end else begin
            unique case (state)
                StIdle: begin
                    // A stray response with nothing outstanding is ignored.
                    state        <= StIdle;
                    load_pending <= 1'b0;
                    pending_rd   <= 5'd0;
                end
                StLoadWait: begin
                    if (MEM_rsp_valid) begin
                        state        <= StIdle;
                        load_pending <= 1'b0;
                        pending_rd   <= 5'd0;
                    end
                end
                default: begin
                    state        <= StIdle;
                    load_pending <= 1'b0;
                    pending_rd   <= 5'd0;
                end
            endcase
        end
    end

    // Saturating stall counter.
    always_ff @(posedge clock) begin
        if (reset) begin
            stall_cnt <= '0;
        end else if (IDU_stall && (stall_cnt != {CNT_W{1'b1}})) begin
            stall_cnt <= stall_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

endmodule

// File: tb/tb_load_use_interlock.sv
module tb_load_use_interlock;

    logic        clock = 1'b0;
    logic        reset;
    logic        IDU_valid;
    logic [4:0]  IDU_rs1;
    logic [4:0]  IDU_rs2;
    logic        IDU_rs1_used;
    logic        IDU_rs2_used;
    logic        EXU_valid;
    logic [4:0]  EXU_rd;
    logic        EXU_R_Wen;
    logic        EXU_mem_ren;
    logic        EXU_fire;
    logic        MEM_rsp_valid;
    logic        flush;

    logic        stall16;
    logic        lp16;
    logic [4:0]  prd16;
    logic [15:0] cnt16;
    logic        stall4;
    logic        lp4;
    logic [4:0]  prd4;
    logic [3:0]  cnt4;

    int checks = 0;
    int errors = 0;

    always #5 clock = ~clock;

    load_use_interlock dut (
        .clock        (clock),
        .reset        (reset),
        .IDU_valid    (IDU_valid),
        .IDU_rs1      (IDU_rs1),
        .IDU_rs2      (IDU_rs2),
        .IDU_rs1_used (IDU_rs1_used),
        .IDU_rs2_used (IDU_rs2_used),
        .EXU_valid    (EXU_valid),
        .EXU_rd       (EXU_rd),
        .EXU_R_Wen    (EXU_R_Wen),
        .EXU_mem_ren  (EXU_mem_ren),
        .EXU_fire     (EXU_fire),
        .MEM_rsp_valid(MEM_rsp_valid),
        .flush        (flush),
        .IDU_stall    (stall16),
        .load_pending (lp16),
        .pending_rd   (prd16),
        .stall_cnt    (cnt16)
    );

    load_use_interlock #(.CNT_W(4)) dut4 (
        .clock        (clock),
        .reset        (reset),
        .IDU_valid    (IDU_valid),
        .IDU_rs1      (IDU_rs1),
        .IDU_rs2      (IDU_rs2),
        .IDU_rs1_used (IDU_rs1_used),
        .IDU_rs2_used (IDU_rs2_used),
        .EXU_valid    (EXU_valid),
        .EXU_rd       (EXU_rd),
        .EXU_R_Wen    (EXU_R_Wen),
        .EXU_mem_ren  (EXU_mem_ren),
        .EXU_fire     (EXU_fire),
        .MEM_rsp_valid(MEM_rsp_valid),
        .flush        (flush),
        .IDU_stall    (stall4),
        .load_pending (lp4),
        .pending_rd   (prd4),
        .stall_cnt    (cnt4)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance past the next rising edge; inputs change and outputs are sampled here.
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic clear_inputs();
        IDU_valid = 0; IDU_rs1 = 0; IDU_rs2 = 0; IDU_rs1_used = 0; IDU_rs2_used = 0;
        EXU_valid = 0; EXU_rd = 0; EXU_R_Wen = 0; EXU_mem_ren = 0; EXU_fire = 0;
        MEM_rsp_valid = 0; flush = 0;
    endtask

    task automatic decode_reads(input logic [4:0] rs1, input logic u1,
                                input logic [4:0] rs2, input logic u2);
        IDU_valid = 1; IDU_rs1 = rs1; IDU_rs1_used = u1; IDU_rs2 = rs2; IDU_rs2_used = u2;
    endtask

    task automatic exu_load(input logic [4:0] rd, input logic wen, input logic fire);
        EXU_valid = 1; EXU_rd = rd; EXU_R_Wen = wen; EXU_mem_ren = 1; EXU_fire = fire;
    endtask

    initial begin
        clear_inputs();
        reset = 1;
        // Hazard and capture present during reset: no stall, no capture.
        decode_reads(5'd5, 1, 5'd0, 0);
        exu_load(5'd5, 1, 1);
        #1;
        chk("stall_in_reset", {31'd0, stall16}, 32'd0);
        tick();
        tick();
        chk("rst_load_pending", {31'd0, lp16}, 32'd0);
        chk("rst_pending_rd", {27'd0, prd16}, 32'd0);
        chk("rst_stall_cnt", {16'd0, cnt16}, 32'd0);
        chk("rst_stall_cnt4", {28'd0, cnt4}, 32'd0);

        // Load x5 in EX, decode reads x5: stall now, capture on fire.
        reset = 0;
        #1;
        chk("ex_hazard_stall", {31'd0, stall16}, 32'd1);
        tick();
        chk("capture_lp", {31'd0, lp16}, 32'd1);
        chk("capture_rd", {27'd0, prd16}, 32'd5);
        chk("cnt_after_1", {16'd0, cnt16}, 32'd1);

        // LOAD_WAIT, decode keeps reading x5: three stalls then response.
        clear_inputs();
        decode_reads(5'd5, 1, 5'd0, 0);
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("mem_hazard_stall", {31'd0, stall16}, 32'd1);
            tick();
        end
        chk("cnt_after_4", {16'd0, cnt16}, 32'd4);
        chk("lp_held", {31'd0, lp16}, 32'd1);
        chk("rd_held", {27'd0, prd16}, 32'd5);
        // Same register but not marked used: no dependency.
        decode_reads(5'd5, 0, 5'd5, 0);
        #1;
        chk("unused_src_nostall", {31'd0, stall16}, 32'd0);
        tick();
        decode_reads(5'd5, 1, 5'd0, 0);
        MEM_rsp_valid = 1;
        #1;
        chk("rsp_forward_nostall", {31'd0, stall16}, 32'd0);
        tick();
        chk("rsp_exit_lp", {31'd0, lp16}, 32'd0);
        chk("rsp_exit_rd", {27'd0, prd16}, 32'd0);
        chk("cnt_after_rsp", {16'd0, cnt16}, 32'd4);
        chk("cnt4_after_rsp", {28'd0, cnt4}, 32'd4);

        // Load to x0: never stalls, never captured.
        clear_inputs();
        decode_reads(5'd0, 1, 5'd0, 1);
        exu_load(5'd0, 1, 1);
        #1;
        chk("x0_nostall", {31'd0, stall16}, 32'd0);
        tick();
        chk("x0_no_capture", {31'd0, lp16}, 32'd0);

        // Load without register write: never stalls, never captured.
        decode_reads(5'd5, 1, 5'd0, 0);
        exu_load(5'd5, 0, 1);
        #1;
        chk("nowen_nostall", {31'd0, stall16}, 32'd0);
        tick();
        chk("nowen_no_capture", {31'd0, lp16}, 32'd0);

        // Response in IDLE is ignored.
        clear_inputs();
        MEM_rsp_valid = 1;
        tick();
        chk("rsp_idle_ignored", {31'd0, lp16}, 32'd0);

        // Capture x5 with decode idle, then response plus capture x7.
        clear_inputs();
        exu_load(5'd5, 1, 1);
        #1;
        chk("capture_idle_dec_nostall", {31'd0, stall16}, 32'd0);
        tick();
        chk("capture5_rd", {27'd0, prd16}, 32'd5);
        exu_load(5'd7, 1, 1);
        MEM_rsp_valid = 1;
        tick();
        chk("rsp_capture_lp", {31'd0, lp16}, 32'd1);
        chk("rsp_capture_rd", {27'd0, prd16}, 32'd7);

        // rs2 dependency on the pending load.
        clear_inputs();
        decode_reads(5'd0, 1, 5'd7, 1);
        #1;
        chk("rs2_mem_stall", {31'd0, stall16}, 32'd1);
        tick();
        chk("cnt_after_rs2", {16'd0, cnt16}, 32'd5);

        // Flush with a matching decode and a capture: no stall, back to IDLE.
        flush = 1;
        exu_load(5'd9, 1, 1);
        #1;
        chk("flush_nostall", {31'd0, stall16}, 32'd0);
        tick();
        chk("flush_lp", {31'd0, lp16}, 32'd0);
        chk("flush_rd", {27'd0, prd16}, 32'd0);
        chk("cnt_after_flush", {16'd0, cnt16}, 32'd5);

        // Hold an EX hazard for 20 cycles: the 4-bit counter saturates.
        clear_inputs();
        decode_reads(5'd3, 1, 5'd0, 0);
        exu_load(5'd3, 1, 0);
        repeat (20) tick();
        chk("sat_cnt4", {28'd0, cnt4}, 32'd15);
        chk("cnt16_25", {16'd0, cnt16}, 32'd25);
        EXU_fire = 1;
        tick();
        chk("sat_cnt4_held", {28'd0, cnt4}, 32'd15);
        chk("cnt16_26", {16'd0, cnt16}, 32'd26);
        chk("capture3_lp", {31'd0, lp4}, 32'd1);
        chk("capture3_rd", {27'd0, prd4}, 32'd3);

        // Reset mid-LOAD_WAIT while stalling, with a capture and flush present.
        EXU_rd = 5'd4;
        flush = 0;
        reset = 1;
        #1;
        chk("stall_low_in_reset", {31'd0, stall16}, 32'd0);
        tick();
        chk("midrst_lp", {31'd0, lp16}, 32'd0);
        chk("midrst_rd", {27'd0, prd16}, 32'd0);
        chk("midrst_cnt", {16'd0, cnt16}, 32'd0);
        chk("midrst_cnt4", {28'd0, cnt4}, 32'd0);
        chk("midrst_lp4", {31'd0, lp4}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
